// File: rtl/ik_pkg.sv
// rtl/ik_pkg.sv - shared constants, state encoding and result layout for the IK job sequencer
package ik_pkg;

    localparam int BIT_WIDTH = 32;
    localparam int FRACTIONS = 15;

    // Squared-radius limits in the Q(2*FRACTIONS) domain of the summed magnitude squares
    localparam logic [63:0] REACH_MIN = 64'd1 << (2 * FRACTIONS);
    localparam logic [63:0] REACH_MAX = 64'd529 << (2 * FRACTIONS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DRIVE = 2'd2
    } ik_state_e;

    // Result record layout, LSB first: theta1, theta2, tag, then unreach as the MSB
    localparam int THETA1_LSB = 0;
    localparam int THETA2_LSB = BIT_WIDTH;
    localparam int TAG_LSB    = 2 * BIT_WIDTH;

    function automatic logic [63:0] mag_sq(input logic [BIT_WIDTH-1:0] v);
        logic [63:0] m;
        m = {{(64 - (BIT_WIDTH - 1)){1'b0}}, v[BIT_WIDTH-2:0]};
        return m * m;
    endfunction

endpackage

// File: rtl/ik_result_fifo.sv
// rtl/ik_result_fifo.sv - result queue with registered head and occupancy count
module ik_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic             pop;
    logic [AW:0]      remain;

    assign pop     = rd_en && head_valid;
    assign rd_next = rd_ptr + AW'(pop);
    // Entries already in storage once this cycle's pop is retired; a same-cycle write shows up a cycle later
    assign remain  = count - (AW+1)'(pop);

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_next;
            count      <= remain + (AW+1)'(wr_en);
            head_valid <= (remain != '0);
            head_data  <= (remain != '0) ? mem[rd_next] : '0;
        end
    end

endmodule

// File: rtl/ik_job_sequencer.sv
// rtl/ik_job_sequencer.sv - serialises (x, y) jobs into the IK core and queues thetas; IK_REACH_CHECK_EN adds the reach check
module ik_job_sequencer
    import ik_pkg::*;
#(
    parameter int SETTLE_CYCLES = 12,
    parameter int FIFO_DEPTH    = 4,
    parameter int TAG_W         = 4
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [BIT_WIDTH-1:0] req_x,
    input  logic [BIT_WIDTH-1:0] req_y,
    input  logic [TAG_W-1:0]     req_tag,
    output logic [BIT_WIDTH-1:0] x_drv,
    output logic [BIT_WIDTH-1:0] y_drv,
    input  logic [BIT_WIDTH-1:0] th1_in,
    input  logic [BIT_WIDTH-1:0] th2_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [BIT_WIDTH-1:0] res_theta1,
    output logic [BIT_WIDTH-1:0] res_theta2,
    output logic [TAG_W-1:0]     res_tag,
    output logic                 res_unreach,
    output logic                 busy
);

    localparam int RES_W = 2 * BIT_WIDTH + TAG_W + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    ik_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             push;
    logic [RES_W-1:0] push_data;
    logic             pop;
    logic [RES_W-1:0] head_data;
    logic [AW:0]      fifo_count;

    // A job is only taken when its result slot is already free, so the FIFO can never overflow
    assign req_ready = (state == ST_IDLE) && (fifo_count < FULL_CNT) && rst;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != ST_IDLE);
    assign pop       = res_valid && res_ready;

`ifdef IK_REACH_CHECK_EN
    logic [63:0] reach_sum;
    logic        reachable;

    assign reach_sum = mag_sq(x_drv) + mag_sq(y_drv);
    assign reachable = (reach_sum >= REACH_MIN) && (reach_sum <= REACH_MAX);
`endif

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (state == ST_DRIVE && cnt == '0) begin
            push      = 1'b1;
            push_data = {1'b0, tag_q, th2_in, th1_in};
        end
`ifdef IK_REACH_CHECK_EN
        else if (state == ST_CHECK && !reachable) begin
            push      = 1'b1;
            push_data = {1'b1, tag_q, {(2 * BIT_WIDTH){1'b0}}};
        end
`endif
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            tag_q <= '0;
            x_drv <= '0;
            y_drv <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        x_drv <= req_x;
                        y_drv <= req_y;
                        tag_q <= req_tag;
`ifdef IK_REACH_CHECK_EN
                        state <= ST_CHECK;
`else
                        state <= ST_DRIVE;
                        cnt   <= CNT_LOAD;
`endif
                    end
                end
`ifdef IK_REACH_CHECK_EN
                ST_CHECK: begin
                    if (reachable) begin
                        state <= ST_DRIVE;
                        cnt   <= CNT_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
`endif
                ST_DRIVE: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ik_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_result_fifo (
        .clock      (clock),
        .rst        (rst),
        .wr_en      (push),
        .wr_data    (push_data),
        .rd_en      (pop),
        .head_valid (res_valid),
        .head_data  (head_data),
        .count      (fifo_count)
    );

    assign res_theta1  = head_data[THETA1_LSB +: BIT_WIDTH];
    assign res_theta2  = head_data[THETA2_LSB +: BIT_WIDTH];
    assign res_tag     = head_data[TAG_LSB +: TAG_W];
    assign res_unreach = head_data[RES_W-1];

endmodule

// File: tb/tb_ik_job_sequencer.sv
// tb/tb_ik_job_sequencer.sv - self-checking bench for ik_job_sequencer (either IK_REACH_CHECK_EN build)
module tb_ik_job_sequencer;

    localparam int SETTLE = 12;
`ifdef IK_REACH_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic        clock = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic [3:0]  req_tag;
    logic [31:0] x_drv;
    logic [31:0] y_drv;
    logic [31:0] th1_in;
    logic [31:0] th2_in;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_theta1;
    logic [31:0] res_theta2;
    logic [3:0]  res_tag;
    logic        res_unreach;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  tag;
        logic [31:0] th1;
        logic [31:0] th2;
        logic        unreach;
    } vec_t;

    vec_t vecs[8];

    ik_job_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .FIFO_DEPTH    (4),
        .TAG_W         (4)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_tag     (req_tag),
        .x_drv       (x_drv),
        .y_drv       (y_drv),
        .th1_in      (th1_in),
        .th2_in      (th2_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_theta1  (res_theta1),
        .res_theta2  (res_theta2),
        .res_tag     (res_tag),
        .res_unreach (res_unreach),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [31:0] x, input logic [31:0] y, input logic [3:0] tag,
                         input int max_wait, output bit ok);
        req_x     = x;
        req_y     = y;
        req_tag   = tag;
        req_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            if (req_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic run_vector(input string nm, input vec_t v);
        bit   ok;
        int   lat;
        logic exp_u;
        int   exp_lat;
        th1_in    = v.th1;
        th2_in    = v.th2;
        res_ready = 1'b1;
        exp_u     = (CHK != 0) ? v.unreach : 1'b0;
        exp_lat   = exp_u ? 2 : SETTLE + CHK + 1;
        offer(v.x, v.y, v.tag, 40, ok);
        chk({nm, "_accept"}, 64'(ok), 64'd1);
        chk({nm, "_x_drv"}, 64'(x_drv), 64'(v.x));
        chk({nm, "_y_drv"}, 64'(y_drv), 64'(v.y));
        chk({nm, "_busy"}, 64'(busy), 64'd1);
        chk({nm, "_ready_low"}, 64'(req_ready), 64'd0);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (res_valid) begin
                lat = k;
                break;
            end
        end
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_theta1"}, 64'(res_theta1), exp_u ? 64'd0 : 64'(v.th1));
        chk({nm, "_theta2"}, 64'(res_theta2), exp_u ? 64'd0 : 64'(v.th2));
        chk({nm, "_tag"}, 64'(res_tag), 64'(v.tag));
        chk({nm, "_unreach"}, 64'(res_unreach), 64'(exp_u));
        tick();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({nm, "_xy_drv"}, {x_drv, y_drv}, 64'd0);
        chk({nm, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({nm, "_thetas"}, {res_theta1, res_theta2}, 64'd0);
        chk({nm, "_tag_unreach"}, 64'({res_tag, res_unreach}), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit ok;
        int accepted;
        int seen;

        vecs[0] = '{32'h0005_0000, 32'h0002_8000, 4'd3,  32'h0000_1234, 32'h0000_5678, 1'b0};
        vecs[1] = '{32'h000F_0000, 32'h0000_0000, 4'd5,  32'h1111_1111, 32'h2222_2222, 1'b1};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 4'd6,  32'h3333_3333, 32'h4444_4444, 1'b1};
        vecs[3] = '{32'h8001_8000, 32'h0002_0000, 4'd7,  32'hAAAA_0001, 32'h5555_0002, 1'b0};
        vecs[4] = '{32'h0000_8000, 32'h0000_0000, 4'd8,  32'h0000_0808, 32'h0000_0909, 1'b0};
        vecs[5] = '{32'h000B_8000, 32'h8000_0000, 4'd9,  32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0};
        vecs[6] = '{32'h000B_8001, 32'h0000_0000, 4'd10, 32'h0BAD_0BAD, 32'h0FED_0FED, 1'b1};
        vecs[7] = '{32'h0000_7FFF, 32'h0000_0000, 4'd11, 32'h0101_0101, 32'h0202_0202, 1'b1};

        rst       = 1'b0;
        req_valid = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_tag   = '0;
        th1_in    = '0;
        th2_in    = '0;
        res_ready = 1'b0;

        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b1;
        #1;
        chk("post_reset_req_ready", 64'(req_ready), 64'd1);
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vector($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: four results fill the FIFO, further jobs are refused
        res_ready = 1'b0;
        th1_in    = 32'h0000_00AA;
        th2_in    = 32'h0000_00BB;
        accepted  = 0;
        for (int t = 1; t <= 6; t++) begin
            offer(32'h0005_0000, 32'h0000_0000, 4'(t), 40, ok);
            if (ok) accepted++;
        end
        chk("bp_accepted", 64'(accepted), 64'd4);
        chk("bp_ready_low", 64'(req_ready), 64'd0);
        chk("bp_head_tag", 64'({res_valid, res_tag}), 64'({1'b1, 4'd1}));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_ready_after_pop", 64'(req_ready), 64'd1);
        chk("bp_head_after_pop", 64'({res_valid, res_tag}), 64'({1'b1, 4'd2}));
        res_ready = 1'b1;
        tick();
        chk("bp_drain3", 64'({res_valid, res_tag}), 64'({1'b1, 4'd3}));
        tick();
        chk("bp_drain4", 64'({res_valid, res_tag}), 64'({1'b1, 4'd4}));
        tick();
        chk("bp_empty", 64'(res_valid), 64'd0);
        res_ready = 1'b0;
        tick();

        // Same-cycle push and pop with two entries queued
        offer(32'h0005_0000, 32'h0, 4'd1, 40, ok);
        offer(32'h0005_0000, 32'h0, 4'd2, 40, ok);
        th1_in = 32'h0000_0C0C;
        offer(32'h0005_0000, 32'h0, 4'd3, 40, ok);
        chk("pp_accept", 64'(ok), 64'd1);
        repeat (SETTLE + CHK - 1) tick();
        chk("pp_pre_head", 64'({res_valid, res_tag}), 64'({1'b1, 4'd1}));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("pp_head_after", 64'({res_valid, res_tag}), 64'({1'b1, 4'd2}));
        chk("pp_idle", 64'(busy), 64'd0);
        res_ready = 1'b1;
        tick();
        chk("pp_third", 64'({res_valid, res_tag, res_theta1}), 64'({1'b1, 4'd3, 32'h0000_0C0C}));
        tick();
        chk("pp_empty", 64'(res_valid), 64'd0);
        res_ready = 1'b0;
        tick();

        // Reset in the middle of a drive with two results queued
        offer(32'h0005_0000, 32'h0, 4'd1, 40, ok);
        offer(32'h0005_0000, 32'h0, 4'd2, 40, ok);
        offer(32'h0005_0000, 32'h0, 4'd3, 40, ok);
        repeat (6 + CHK) tick();
        chk("mr_busy_before", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        tick();
        rst = 1'b1;
        res_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (res_valid) seen++;
        end
        chk("mr_no_stale", 64'(seen), 64'd0);
        run_vector("mr_next", vecs[3]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
